// File: rtl/pipe_register.sv
// Elastic two-entry pipeline register (main + skid) with valid/ready handshake.
// in_ready comes straight from a flop, so no combinational ready path crosses the stage.
module pipe_register #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] indata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [1:0]       count
);

  localparam logic [1:0] StEmpty = 2'b00;
  localparam logic [1:0] StOne   = 2'b10;
  localparam logic [1:0] StFull  = 2'b11;

  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             main_v_q, main_v_d;
  logic             skid_v_q, skid_v_d;
  logic             accept;
  logic             pop;

  assign in_ready  = ~skid_v_q;
  assign out_valid = main_v_q;
  assign out       = main_data_q;
  assign count     = {1'b0, main_v_q} + {1'b0, skid_v_q};

  assign accept = in_valid & ~skid_v_q;
  assign pop    = main_v_q & out_ready;

  always_comb begin
    main_v_d    = main_v_q;
    skid_v_d    = skid_v_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      // Data registers deliberately keep their contents; only the valid bits drop.
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else begin
      case ({main_v_q, skid_v_q})
        StEmpty: begin
          if (accept) begin
            main_v_d    = 1'b1;
            main_data_d = indata;
          end
        end
        StOne: begin
          if (accept && pop) begin
            main_data_d = indata;
          end else if (accept) begin
            skid_v_d    = 1'b1;
            skid_data_d = indata;
          end else if (pop) begin
            main_v_d = 1'b0;
          end
        end
        StFull: begin
          if (pop) begin
            main_data_d = skid_data_q;
            skid_v_d    = 1'b0;
          end
        end
        default: begin
          // Skid without main is unreachable; fall back to empty.
          main_v_d = 1'b0;
          skid_v_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      main_v_q    <= 1'b0;
      skid_v_q    <= 1'b0;
      main_data_q <= RESET_VALUE;
      skid_data_q <= RESET_VALUE;
    end else begin
      main_v_q    <= main_v_d;
      skid_v_q    <= skid_v_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
    end
  end

endmodule
